// File: rtl/ram_dma_pkg.sv
// Shared state encoding and transfer-mode constants for the RAM block-copy/fill engine.
package ram_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/ram_dma_if.sv
// Single-port synchronous RAM bus: address, write data and write enable out, registered read data back.
interface ram_dma_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);

  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  we;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output addr, output wdata, output we, input rdata);
  modport slave  (input addr, input wdata, input we, output rdata);

endinterface

// File: rtl/ram_dma.sv
// Block copy (2 cycles/word) or fill (1 cycle/word) engine on a single-port sync RAM; done pulses one
// cycle after the last write. No backpressure: start is only honoured in IDLE, ignored while running.
module ram_dma
  import ram_dma_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_mode,
  input  logic [ADDR_WIDTH-1:0] i_src,
  input  logic [ADDR_WIDTH-1:0] i_dst,
  input  logic [ADDR_WIDTH:0]   i_len,
  input  logic [DATA_WIDTH-1:0] i_fill,
  output logic                  o_busy,
  output logic                  o_done,
  ram_dma_if.master             ram
);

  localparam logic [ADDR_WIDTH:0] K_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   k_q, k_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic                  mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [DATA_WIDTH-1:0] fill_q, fill_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ADDR_WIDTH:0]   k_inc;
  logic                  we;
  logic                  busy;
  logic                  done;

  assign k_inc = k_q + K_ONE;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    len_d   = len_q;
    mode_d  = mode_q;
    src_d   = src_q;
    dst_d   = dst_q;
    fill_d  = fill_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we      = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          if (i_len != '0) begin
            len_d   = i_len;
            mode_d  = i_mode;
            src_d   = i_src;
            dst_d   = i_dst;
            fill_d  = i_fill;
            k_d     = '0;
            state_d = (i_mode == MODE_FILL) ? ST_WR : ST_RD;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_RD: begin
        addr_d  = src_q + k_q[ADDR_WIDTH-1:0];
        busy    = 1'b1;
        state_d = ST_WR;
      end
      ST_WR: begin
        // Copy data comes straight from the RAM read issued in the preceding RD cycle.
        addr_d = dst_q + k_q[ADDR_WIDTH-1:0];
        data_d = (mode_q == MODE_FILL) ? fill_q : ram.rdata;
        we     = 1'b1;
        busy   = 1'b1;
        k_d    = k_inc;
        if (k_inc == len_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = (mode_q == MODE_FILL) ? ST_WR : ST_RD;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      len_q   <= '0;
      mode_q  <= MODE_COPY;
      src_q   <= '0;
      dst_q   <= '0;
      fill_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      fill_q  <= fill_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign ram.addr  = addr_d;
  assign ram.wdata = data_d;
  assign ram.we    = we;
  assign o_busy    = busy;
  assign o_done    = done;

endmodule

// File: tb/tb_ram_dma.sv
// Bench for ram_dma with a behavioural 256x8 RAM and a transfer-level reference model of the
// expected write sequence, busy/done timing and final memory image.
module tb_ram_dma;
  import ram_dma_pkg::*;

  localparam int AW = 8;
  localparam int DW = 8;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] src = '0;
  logic [7:0] dst = '0;
  logic [8:0] len = '0;
  logic [7:0] fill = '0;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  ram_dma_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ram_bus ();

  ram_dma #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_mode  (mode),
    .i_src   (src),
    .i_dst   (dst),
    .i_len   (len),
    .i_fill  (fill),
    .o_busy  (busy),
    .o_done  (done),
    .ram     (ram_bus.master)
  );

  // Behavioural RAM with a backdoor write port used only while the DMA is idle.
  logic [7:0] mem [256];
  logic       bd_we = 1'b0;
  logic [7:0] bd_addr = '0;
  logic [7:0] bd_data = '0;

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (ram_bus.we) mem[ram_bus.addr] <= ram_bus.wdata;
    ram_bus.rdata <= mem[ram_bus.addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [7:0] ref_mem [256];
  wr_t        plan[$];
  bit         act = 1'b0;
  bit         m_mode = 1'b0;
  logic [7:0] m_src = '0;
  int         m_len = 0;
  int         t0 = 0;
  int         dc0 = 0;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int done_j = 0;
  int busy_tot = 0;
  int we_tot = 0;
  int applied_n = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at cycle %0d", nm, got, want, cyc);
    end
  endtask

  // Compare process: expected outputs derived from the cycle offset within the transfer.
  always @(negedge clk) begin
    int  j, n, idx;
    bit  eb, ed, ew, er;
    logic [7:0] ea, edat;
    if (rst_n) begin
      eb = 0; ed = 0; ew = 0; er = 0; ea = '0; edat = '0; idx = 0;
      if (act) begin
        j = cyc - t0 + 1;
        n = m_mode ? m_len : 2 * m_len;
        if (j == 1) applied_n = 0;
        if (j >= 1 && j <= n) begin
          eb = 1;
          if (m_mode == MODE_FILL) begin
            ew = 1; idx = j - 1;
          end else if (j % 2 == 0) begin
            ew = 1; idx = j / 2 - 1;
          end else begin
            er = 1; ea = m_src + 8'((j - 1) / 2);
          end
        end
        ed = (j == n + 1);
        if (ew && idx < plan.size()) begin
          ea = plan[idx].a;
          edat = plan[idx].d;
          applied_n = idx + 1;
        end
        if (done) done_j = j;
      end
      chk("busy", 32'(busy), 32'(eb));
      chk("done", 32'(done), 32'(ed));
      chk("ram_we", 32'(ram_bus.we), 32'(ew));
      if (ew || er) chk("ram_addr", 32'(ram_bus.addr), 32'(ea));
      if (ew) chk("ram_wdata", 32'(ram_bus.wdata), 32'(edat));
      if (done) done_cnt++;
      if (busy) busy_tot++;
      if (ram_bus.we) we_tot++;
    end
  end

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    bd_addr = a; bd_data = d; bd_we = 1'b1;
    @(negedge clk);
    bd_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic start_xfer(input bit md, input logic [7:0] s, input logic [7:0] d,
                            input int n, input logic [7:0] f);
    logic [7:0] tmp [256];
    @(negedge clk);
    start = 1'b1; mode = md; src = s; dst = d; len = 9'(n); fill = f;
    @(posedge clk);
    #1;
    start = 1'b0;
    plan.delete();
    tmp = ref_mem;
    for (int i = 0; i < n; i++) begin
      wr_t w;
      w.a = d + 8'(i);
      w.d = md ? f : tmp[s + 8'(i)];
      tmp[w.a] = w.d;
      plan.push_back(w);
    end
    m_mode = md; m_src = s; m_len = n; t0 = cyc; dc0 = done_cnt; act = 1'b1;
  endtask

  task automatic check_mem(input string nm);
    int bad = 0;
    checks++;
    for (int i = 0; i < 256; i++) begin
      if (mem[i] !== ref_mem[i]) begin
        if (bad == 0) $display("FAIL %s mem[%0h] got %0h want %0h", nm, i, mem[i], ref_mem[i]);
        bad++;
      end
    end
    if (bad != 0) errors++;
  endtask

  task automatic finish_xfer(input string nm);
    int n = m_mode ? m_len : 2 * m_len;
    bit got = 1'b0;
    for (int c = 0; c < n + 20 && !got; c++) begin
      @(posedge clk);
      #1;
      if (done_cnt != dc0) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s done_timeout got none want pulse", nm);
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < applied_n && i < plan.size(); i++) ref_mem[plan[i].a] = plan[i].d;
    check_mem(nm);
  endtask

  initial begin
    int b0, w0, d0;
    logic [7:0] pre [8];
    logic [7:0] pre_lo, pre_hi;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_we", 32'(ram_bus.we), 0);
    chk("rst_addr", 32'(ram_bus.addr), 0);
    chk("rst_wdata", 32'(ram_bus.wdata), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));

    // Fill
    pre_lo = ref_mem[8'h0F]; pre_hi = ref_mem[8'h14];
    start_xfer(MODE_FILL, 8'h00, 8'h10, 4, 8'hA5);
    finish_xfer("fill");
    chk("fill_done_cycle", 32'(done_j), 5);
    for (int i = 0; i < 4; i++) chk("fill_word", 32'(mem[8'h10 + 8'(i)]), 32'hA5);
    chk("fill_below", 32'(mem[8'h0F]), 32'(pre_lo));
    chk("fill_above", 32'(mem[8'h14]), 32'(pre_hi));

    // Copy
    for (int i = 1; i <= 5; i++) poke(8'(i), 8'(10 * i));
    b0 = busy_tot;
    start_xfer(MODE_COPY, 8'h01, 8'h40, 5, 8'h00);
    finish_xfer("copy");
    chk("copy_done_cycle", 32'(done_j), 11);
    chk("copy_busy_cycles", 32'(busy_tot - b0), 10);
    for (int i = 0; i < 5; i++) begin
      chk("copy_dst", 32'(mem[8'h40 + 8'(i)]), 32'(10 * (i + 1)));
      chk("copy_src", 32'(mem[8'h01 + 8'(i)]), 32'(10 * (i + 1)));
    end

    // Zero length
    w0 = we_tot;
    start_xfer(MODE_FILL, 8'h00, 8'h30, 0, 8'hEE);
    finish_xfer("len0");
    chk("len0_done_cycle", 32'(done_j), 1);
    chk("len0_no_we", 32'(we_tot - w0), 0);

    // Address wrap
    poke(8'hFE, 8'd7); poke(8'hFF, 8'd8); poke(8'h00, 8'd9);
    start_xfer(MODE_COPY, 8'hFE, 8'h80, 3, 8'h00);
    finish_xfer("wrap");
    chk("wrap_80", 32'(mem[8'h80]), 7);
    chk("wrap_81", 32'(mem[8'h81]), 8);
    chk("wrap_82", 32'(mem[8'h82]), 9);

    // Start while busy
    d0 = done_cnt;
    start_xfer(MODE_COPY, 8'h50, 8'h60, 4, 8'h00);
    @(negedge clk); @(negedge clk);
    start = 1'b1; mode = MODE_FILL; dst = 8'hC0; len = 9'd16; fill = 8'h3C;
    @(negedge clk);
    start = 1'b0;
    finish_xfer("start_busy");
    chk("start_busy_done_count", 32'(done_cnt - d0), 1);

    // Reset in the middle of a fill
    for (int i = 0; i < 8; i++) pre[i] = ref_mem[8'h20 + 8'(i)];
    d0 = done_cnt;
    start_xfer(MODE_FILL, 8'h00, 8'h20, 8, 8'h55);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    act = 1'b0;
    #1;
    chk("midrst_we", 32'(ram_bus.we), 0);
    chk("midrst_busy", 32'(busy), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < applied_n && i < plan.size(); i++) ref_mem[plan[i].a] = plan[i].d;
    check_mem("midrst");
    chk("midrst_20", 32'(mem[8'h20]), 32'h55);
    chk("midrst_21", 32'(mem[8'h21]), 32'h55);
    for (int i = 2; i < 8; i++) chk("midrst_untouched", 32'(mem[8'h20 + 8'(i)]), 32'(pre[i]));
    chk("midrst_no_done", 32'(done_cnt - d0), 0);

    // Full-memory fill
    start_xfer(MODE_FILL, 8'h00, 8'h9C, 256, 8'h6B);
    finish_xfer("fill_all");
    for (int i = 0; i < 256; i += 51) chk("fill_all_word", 32'(mem[i]), 32'h6B);
    for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));

    // Randomised transfers, some with ignored start glitches
    for (int r = 0; r < 24; r++) begin
      bit md;
      int sel, n;
      md  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 15);
      n   = (sel == 0) ? 0 : (sel == 1) ? 256 : $urandom_range(1, 24);
      start_xfer(md, 8'($urandom), 8'($urandom), n, 8'($urandom));
      if (n > 1 && $urandom_range(0, 2) == 0) begin
        @(negedge clk);
        start = 1'b1; mode = ~md; src = 8'($urandom); dst = 8'($urandom); len = 9'd9;
        @(negedge clk);
        start = 1'b0;
      end
      finish_xfer("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
